// File: rtl/prm_edge_scan_ctrl_if.sv
// Handshake bundle for prm_edge_scan_ctrl.
//   Obstacle stream : obs_valid/obs_ready/obs_code/obs_last (feeder -> controller)
//   Result stream   : result_valid/result_ready/blocked_mask/obs_cnt (controller -> planner)
// The master modport is the environment side (feeder + consumer), the slave modport is the
// controller.
interface prm_edge_scan_ctrl_if #(
  parameter int unsigned NumEdges = 1024,
  parameter int unsigned CntW     = 16
);
  logic                obs_valid;
  logic                obs_ready;
  logic [14:0]         obs_code;
  logic                obs_last;
  logic                result_valid;
  logic                result_ready;
  logic [NumEdges-1:0] blocked_mask;
  logic [CntW-1:0]     obs_cnt;

  modport master (
    output obs_valid, obs_code, obs_last, result_ready,
    input  obs_ready, result_valid, blocked_mask, obs_cnt
  );

  modport slave (
    input  obs_valid, obs_code, obs_last, result_ready,
    output obs_ready, result_valid, blocked_mask, obs_cnt
  );
endinterface

// File: rtl/prm_edge_scan_ctrl.sv
// PRM edge-scan controller: streams 15-bit obstacle voxel codes to a combinational bank of
// per-edge obstacle checkers and ORs the returned per-edge masks into a blocked-edge mask,
// which is presented once the last code of the scene has been folded in.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   start_i     one-cycle pulse, starts a scene scan (only honoured when idle)
//   bus         prm_edge_scan_ctrl_if.slave: obstacle stream in, result stream out
//   chk_code_o  registered code driven to every checker in the bank
//   chk_mask_i  bank output for chk_code_o, one bit per edge
//   busy_o      high whenever the controller is not idle
//
// Optional feature: define PRM_EARLY_EXIT_EN to stop driving/folding/counting codes once every
// edge is already blocked; the remaining codes of the scene are still accepted and dropped.
module prm_edge_scan_ctrl #(
  parameter int unsigned NumEdges = 1024,
  parameter int unsigned CntW     = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  prm_edge_scan_ctrl_if.slave bus,
  output logic [14:0]         chk_code_o,
  input  logic [NumEdges-1:0] chk_mask_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [14:0]         code_q, code_d;
  logic                pipe_q, pipe_d;
  logic [NumEdges-1:0] mask_q, mask_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic accept;
  logic take;

  assign accept = bus.obs_valid & bus.obs_ready;

`ifdef PRM_EARLY_EXIT_EN
  // Include the mask still in flight so the code right after a saturating one is dropped too.
  logic full;
  assign full = &(mask_q | ({NumEdges{pipe_q}} & chk_mask_i));
  assign take = accept & ~full;
`else
  assign take = accept;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pipe_d  = 1'b0;
    mask_d  = mask_q;
    cnt_d   = cnt_q;

    // The bank answers for chk_code_o one cycle after the accept that loaded it.
    if (pipe_q) begin
      mask_d = mask_q | chk_mask_i;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mask_d  = '0;
          cnt_d   = '0;
          pipe_d  = 1'b0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (take) begin
          code_d = bus.obs_code;
          pipe_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (accept && bus.obs_last) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = StDone;
      end
      StDone: begin
        if (bus.result_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      code_q  <= '0;
      pipe_q  <= 1'b0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pipe_q  <= pipe_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.obs_ready    = (state_q == StScan);
  assign bus.result_valid = (state_q == StDone);
  assign bus.blocked_mask = mask_q;
  assign bus.obs_cnt      = cnt_q;
  assign chk_code_o       = code_q;
  assign busy_o           = (state_q != StIdle);

endmodule
